// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter:
// FSM state encodings, requester count, hold-counter width and a one-hot helper.
package mux4_rr_arbiter_pkg;

  localparam logic ARB_IDLE  = 1'b0;
  localparam logic ARB_GRANT = 1'b1;

  localparam int ARB_N  = 4;
  localparam int ARB_CW = 4;

  function automatic logic [ARB_N-1:0] onehot4(input logic [1:0] idx);
    logic [ARB_N-1:0] vec;
    vec      = 4'b0000;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Wrapped priority scan: returns the first requester at or after 'start',
// wrapping from 3 back to 0.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       start,
  output logic [1:0]       idx,
  output logic             found
);

  logic [2*ARB_N-1:0] req2_s;
  logic [ARB_N-1:0]   rot_s;
  logic [1:0]         off_s;

  // Rotate so that bit 0 of rot_s is the requester at 'start'.
  assign req2_s = {req, req};
  assign rot_s  = req2_s[start +: ARB_N];

  // Offset of the first set bit in the rotated view.
  always_comb begin
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
  end

  assign idx   = start + off_s;
  assign found = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux; each owner keeps
// the grant for at most MAX_HOLD consecutive cycles while others wait.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ARB_N-1:0] req,
  output logic [1:0]       sel,
  output logic [ARB_N-1:0] grant,
  output logic             busy
);

  localparam logic [ARB_CW-1:0] HOLD_LIM = ARB_CW'(MAX_HOLD);

  logic              state_q,    state_d;
  logic [1:0]        owner_q,    owner_d;
  logic [1:0]        last_q,     last_d;
  logic [ARB_CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        sel_q,      sel_d;
  logic [ARB_N-1:0]  grant_q,    grant_d;
  logic              busy_q,     busy_d;

  logic [1:0] pick_start_s;
  logic [1:0] pick_idx_s;
  logic       pick_found_s;
  logic       release_s;

  // After a release last==owner, so both start points are "one past the previous owner".
  always_comb begin
    pick_start_s = last_q + 2'd1;
    if (state_q == ARB_GRANT) begin
      pick_start_s = owner_q + 2'd1;
    end else begin
      pick_start_s = last_q + 2'd1;
    end
  end

  assign release_s = (req[owner_q] == 1'b0) || (hold_cnt_q == HOLD_LIM);

  rr_pick4 u_pick (
    .req   (req),
    .start (pick_start_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Next-state logic for the FSM, hold counter and output registers.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found_s) begin
          state_d    = ARB_GRANT;
          owner_d    = pick_idx_s;
          sel_d      = pick_idx_s;
          grant_d    = onehot4(pick_idx_s);
          busy_d     = 1'b1;
          hold_cnt_d = 4'd1;
        end else begin
          grant_d = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      ARB_GRANT: begin
        if (release_s) begin
          last_d = owner_q;
          if (pick_found_s) begin
            owner_d    = pick_idx_s;
            sel_d      = pick_idx_s;
            grant_d    = onehot4(pick_idx_s);
            busy_d     = 1'b1;
            hold_cnt_d = 4'd1;
          end else begin
            state_d    = ARB_IDLE;
            grant_d    = 4'b0000;
            busy_d     = 1'b0;
            hold_cnt_d = 4'd0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        grant_d    = 4'b0000;
        busy_d     = 1'b0;
        hold_cnt_d = 4'd0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= 2'd0;
      last_q     <= 2'd3;
      hold_cnt_q <= 4'd0;
      sel_q      <= 2'b00;
      grant_q    <= 4'b0000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=2) compared each
// cycle against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_a, req_b;
  logic [1:0] sel_a, sel_b;
  logic [3:0] grant_a, grant_b;
  logic       busy_a, busy_b;

  int n_checks;
  int n_fail;
  int cyc;

  // Model state, index 0 = instance A (hold 4), 1 = instance B (hold 2)
  bit         m_busy [2];
  int         m_owner[2];
  int         m_last [2];
  int         m_cnt  [2];
  logic [1:0] m_sel  [2];

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .sel(sel_a), .grant(grant_a), .busy(busy_a)
  );

  mux4_rr_arbiter #(.MAX_HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .sel(sel_b), .grant(grant_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_busy[u]  = 1'b0;
      m_owner[u] = 0;
      m_last[u]  = 3;
      m_cnt[u]   = 0;
      m_sel[u]   = 2'd0;
    end
  endtask

  task automatic model_step(input int u, input int maxh, input logic [3:0] r);
    int i;
    if (!m_busy[u] || !r[m_owner[u]] || m_cnt[u] == maxh) begin
      if (m_busy[u]) m_last[u] = m_owner[u];
      m_busy[u] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        i = (m_last[u] + k) % 4;
        if (!m_busy[u] && r[i]) begin
          m_busy[u]  = 1'b1;
          m_owner[u] = i;
          m_sel[u]   = 2'(i);
          m_cnt[u]   = 1;
        end
      end
    end else begin
      m_cnt[u] = m_cnt[u] + 1;
    end
  endtask

  function automatic logic [6:0] exp_out(input int u);
    logic [3:0] g;
    g = m_busy[u] ? (4'b0001 << m_owner[u]) : 4'b0000;
    return {g, m_sel[u], m_busy[u]};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    model_step(0, 4, req_a);
    model_step(1, 2, req_b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_a = 4'b1111;
    req_b = 4'b1111;
    rst   = 1'b1;
    #1;
    n_checks++;
    if ({grant_a, sel_a, busy_a} !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL reset_a: got %b expected %b", {grant_a, sel_a, busy_a}, 7'b0000_00_0);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({grant_b, sel_b, busy_b} !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL reset_held_b: got %b expected %b", {grant_b, sel_b, busy_b}, 7'b0000_00_0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle();
    n_checks++;
    if (grant_a !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b expected %b", grant_a, 4'b0001);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_a = 4'b0100;
    req_b = 4'b0000;
    for (int n = 0; n < 6; n++) begin
      if (n == 3) req_a = 4'b0000;
      cycle();
      n_checks++;
      if ({grant_a, sel_a, busy_a} !== exp_out(0)) begin
        n_fail++;
        $display("FAIL single cyc %0d: got %b expected %b", n, {grant_a, sel_a, busy_a}, exp_out(0));
      end
    end
    n_checks++;
    if ({grant_a, sel_a, busy_a} !== 7'b0000_10_0) begin
      n_fail++;
      $display("FAIL single_sel_hold: got %b expected %b", {grant_a, sel_a, busy_a}, 7'b0000_10_0);
    end
  endtask

  task automatic test_contention();
    logic [3:0] want;
    do_reset();
    req_a = 4'b1111;
    for (int n = 0; n < 20; n++) begin
      cycle();
      want = 4'b0001 << ((n / 4) % 4);
      n_checks++;
      if (grant_a !== want || sel_a !== 2'((n / 4) % 4) || busy_a !== 1'b1) begin
        n_fail++;
        $display("FAIL contention cyc %0d: got g=%b s=%0d b=%b expected g=%b", n, grant_a, sel_a, busy_a, want);
      end
    end
  endtask

  task automatic test_handoff();
    do_reset();
    req_a = 4'b1000;
    cycle();
    req_a = 4'b1001;
    cycle();
    n_checks++;
    if (grant_a !== 4'b1000) begin
      n_fail++;
      $display("FAIL handoff_owner: got %b expected %b", grant_a, 4'b1000);
    end
    req_a = 4'b0001;
    cycle();
    n_checks++;
    if ({grant_a, sel_a, busy_a} !== 7'b0001_00_1) begin
      n_fail++;
      $display("FAIL handoff_wrap: got %b expected %b", {grant_a, sel_a, busy_a}, 7'b0001_00_1);
    end
  endtask

  task automatic test_sole_limit();
    do_reset();
    req_b = 4'b0010;
    for (int n = 0; n < 8; n++) begin
      cycle();
      n_checks++;
      if ({grant_b, sel_b, busy_b} !== 7'b0010_01_1) begin
        n_fail++;
        $display("FAIL sole_limit cyc %0d: got %b expected %b", n, {grant_b, sel_b, busy_b}, 7'b0010_01_1);
      end
    end
    req_b = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_a = 4'b0100;
    cycle();
    n_checks++;
    if (grant_a !== 4'b0100) begin
      n_fail++;
      $display("FAIL async_pre: got %b expected %b", grant_a, 4'b0100);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({grant_a, sel_a, busy_a} !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL async_clear: got %b expected %b", {grant_a, sel_a, busy_a}, 7'b0000_00_0);
    end
    #1;
    rst = 1'b0;
    model_reset();
    cycle();
    n_checks++;
    if (grant_a !== 4'b0100) begin
      n_fail++;
      $display("FAIL async_resume: got %b expected %b", grant_a, 4'b0100);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) req_a = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_b = 4'($urandom);
      cycle();
      n_checks++;
      if ({grant_a, sel_a, busy_a} !== exp_out(0)) begin
        n_fail++;
        $display("FAIL random_a cyc %0d: got %b expected %b", n, {grant_a, sel_a, busy_a}, exp_out(0));
      end
      n_checks++;
      if ({grant_b, sel_b, busy_b} !== exp_out(1)) begin
        n_fail++;
        $display("FAIL random_b cyc %0d: got %b expected %b", n, {grant_b, sel_b, busy_b}, exp_out(1));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b1;
    req_a    = 4'b0000;
    req_b    = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_contention();
    test_handoff();
    test_sole_limit();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
